dds_param_scheduler: RTL

- Upstream feeder of the DDS phase MAC.
- Generates the free-running timestamp (MAC D).
- Buffers timed parameter-update commands (frequency, phase, phase-reset) in a small FIFO.
- Applies each command on the exact cycle the timestamp reaches its apply time, driving MAC inputs A (timeoffset), B (freq), C (phase) and D (timestamp) from registers.

---
 rtl/dds_param_scheduler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/dds_param_scheduler.sv
// -----------------------------------------------------------------------------
// dds_param_scheduler
//
// Upstream feeder of the DDS phase MAC. Keeps the free-running timestamp
// (MAC D), queues timed parameter-update commands in a small FIFO, and applies
// the FIFO head on the exact edge where the timestamp reaches the command's
// apply time. After that edge the MAC inputs A (timeoffset), B (freq),
// C (phase) and D (timestamp) all show the new values in the same cycle.
//
// Configuration macro:
//   DDS_LATE_DROP_EN  defined   : a late head is popped and discarded
//                                 (parameters unchanged, late_flag set).
//                     undefined : a late head is applied at once
//                                 (late_flag set).
//
// Parameters:
//   FIFO_DEPTH  command FIFO entries (power of 2, >= 2)
//   TS_WIDTH    width of timestamp, cmd_time, freq and timeoffset
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   run              timestamp count enable
//   ts_clear         synchronous timestamp clear (priority over run)
//   fifo_flush       synchronous discard of every queued command
//   cmd_valid/ready  command handshake
//   cmd_time         apply timestamp
//   cmd_freq         frequency word
//   cmd_phase        phase word
//   cmd_phase_reset  re-zero the phase origin at apply time
//   late_clear       clears late_flag
//   timestamp        current timestamp           (MAC D)
//   freq             active frequency            (MAC B)
//   phase            active phase                (MAC C)
//   timeoffset       active time offset          (MAC A)
//   fifo_count       number of queued commands
//   late_flag        sticky: a command was late (applied late or dropped)
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is a register that reflects whether the
// FIFO had a free slot before the edge; a pop in the same cycle does not open
// a slot for a push while the FIFO is full. cmd_valid may be raised or dropped
// at any time; the payload is sampled only on the transfer edge.
// -----------------------------------------------------------------------------
module dds_param_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH   = 48
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          run,
  input  logic                          ts_clear,
  input  logic                          fifo_flush,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [TS_WIDTH-1:0]           cmd_time,
  input  logic [TS_WIDTH-1:0]           cmd_freq,
  input  logic [13:0]                   cmd_phase,
  input  logic                          cmd_phase_reset,
  input  logic                          late_clear,
  output logic [TS_WIDTH-1:0]           timestamp,
  output logic [TS_WIDTH-1:0]           freq,
  output logic [13:0]                   phase,
  output logic [TS_WIDTH-1:0]           timeoffset,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          late_flag
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Command storage. The payload arrays carry no reset: an entry is only read
  // while fifo_count says it holds a written command.
  // ---------------------------------------------------------------------------
  logic [TS_WIDTH-1:0] mem_time   [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] mem_freq   [FIFO_DEPTH];
  logic [13:0]         mem_phase  [FIFO_DEPTH];
  logic                mem_preset [FIFO_DEPTH];

  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;

  // Head view
  logic [TS_WIDTH-1:0] head_time;
  logic [TS_WIDTH-1:0] head_freq;
  logic [13:0]         head_phase;
  logic                head_preset;
  logic                head_valid;

  // Next-state / control
  logic [TS_WIDTH-1:0] ts_next;
  logic                head_due;
  logic                head_late;
  logic                push;
  logic                pop;
  logic                apply;
  logic [CW-1:0]       count_next;

  assign head_time   = mem_time[rd_ptr];
  assign head_freq   = mem_freq[rd_ptr];
  assign head_phase  = mem_phase[rd_ptr];
  assign head_preset = mem_preset[rd_ptr];
  assign head_valid  = (fifo_count != '0);

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  always_comb begin
    ts_next    = timestamp;
    head_due   = 1'b0;
    head_late  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    apply      = 1'b0;
    count_next = fifo_count;

    if (ts_clear) begin
      ts_next = '0;
    end else if (run) begin
      ts_next = timestamp + TS_WIDTH'(1);
    end

    // Compare against the timestamp the outputs will show after this edge,
    // so the new parameters line up with timestamp == cmd_time. A flush
    // suppresses any apply in the same cycle.
    if (head_valid && !fifo_flush) begin
      head_due  = (head_time == ts_next);
      head_late = (head_time <  ts_next);
    end

    pop  = head_due || head_late;
    push = cmd_valid && cmd_ready && !fifo_flush;

`ifdef DDS_LATE_DROP_EN
    apply = head_due;
`else
    apply = pop;
`endif

    if (fifo_flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = fifo_count + CW'(1);
    end else if (pop && !push) begin
      count_next = fifo_count - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Payload write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem_time[wr_ptr]   <= cmd_time;
      mem_freq[wr_ptr]   <= cmd_freq;
      mem_phase[wr_ptr]  <= cmd_phase;
      mem_preset[wr_ptr] <= cmd_phase_reset;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, count and ready
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      cmd_ready  <= 1'b0;
    end else begin
      if (fifo_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_count <= count_next;
      // Registered so cmd_ready never depends on this cycle's pop.
      cmd_ready  <= (count_next < DEPTH_C);
    end
  end

  // ---------------------------------------------------------------------------
  // Timestamp and MAC parameter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timestamp  <= '0;
      freq       <= '0;
      phase      <= '0;
      timeoffset <= '0;
    end else begin
      timestamp <= ts_next;
      if (apply) begin
        freq  <= head_freq;
        phase <= head_phase;
        // Two's-complement negation of the apply time makes
        // timestamp + timeoffset wrap to zero on the apply cycle.
        if (head_preset) timeoffset <= ~head_time + TS_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky late indicator: setting wins over a simultaneous clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      late_flag <= 1'b0;
    end else if (head_late) begin
      late_flag <= 1'b1;
    end else if (late_clear) begin
      late_flag <= 1'b0;
    end
  end

endmodule
